noise_voice: RTL and testbench

NOISE_VOICE -- requirements
Module: noise_voice

---
 rtl/noise_pkg.sv | 15 +
 rtl/noise_env.sv | 78 +++++++
 rtl/noise_voice.sv | 88 ++++++++
 tb/tb_noise_voice.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared types and width constants for the enveloped noise voice.
package noise_pkg;

    localparam int unsigned NOISE_W          = 24;
    localparam int unsigned PERIOD_W_DEFAULT = 16;
    localparam int unsigned ENV_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/noise_env.sv
// Attack/sustain/release envelope generator; advances only on sample ticks.
module noise_env
    import noise_pkg::*;
#(
    parameter int unsigned ENV_W = ENV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] release_step,
    input  logic [ENV_W-1:0] level,
    output logic [ENV_W-1:0] env,
    output logic             busy
);

    env_state_t       state;
    env_state_t       state_nxt;
    logic [ENV_W-1:0] env_nxt;
    logic [ENV_W:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENV_IDLE;
            env   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
        end
    end

    // Carry bit of sum keeps the attack from wrapping past full scale.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        sum       = {1'b0, env} + {1'b0, attack_step};
        if (tick) begin
            case (state)
                ENV_IDLE: begin
                    env_nxt = '0;
                    if (gate) state_nxt = ENV_ATTACK;
                end
                ENV_ATTACK: begin
                    if (!gate) begin
                        state_nxt = ENV_RELEASE;
                    end else if (sum >= {1'b0, level}) begin
                        env_nxt   = level;
                        state_nxt = ENV_SUSTAIN;
                    end else begin
                        env_nxt = sum[ENV_W-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    if (!gate) state_nxt = ENV_RELEASE;
                    else       env_nxt   = level;
                end
                ENV_RELEASE: begin
                    if (gate) begin
                        state_nxt = ENV_ATTACK;
                    end else if (env <= release_step) begin
                        env_nxt   = '0;
                        state_nxt = ENV_IDLE;
                    end else begin
                        env_nxt = env - release_step;
                    end
                end
                default: begin
                    env_nxt   = '0;
                    state_nxt = ENV_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ENV_IDLE);

endmodule

// File: rtl/noise_voice.sv
// Noise voice: rate divider for an upstream noise source, sample hold, and
// envelope-scaled output through a two-stage multiply pipeline.
module noise_voice
    import noise_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEFAULT,
    parameter int unsigned ENV_W    = ENV_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic                gate,
    input  logic [PERIOD_W-1:0] period,
    input  logic [ENV_W-1:0]    attack_step,
    input  logic [ENV_W-1:0]    release_step,
    input  logic [ENV_W-1:0]    level,
    output logic                noise_en,
    input  logic [NOISE_W-1:0]  noise_in,
    output logic [NOISE_W-1:0]  wave_out,
    output logic                wave_valid,
    output logic                busy
);

    localparam int unsigned PROD_W = NOISE_W + ENV_W;

    logic [PERIOD_W-1:0]      cnt;
    logic [PERIOD_W-1:0]      reload_c;
    logic                     cap_pend;
    logic signed [NOISE_W-1:0] hold;
    logic [ENV_W-1:0]         env;
    logic signed [ENV_W:0]    env_s;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod;
    logic                     v1;
    logic                     v2;

    noise_env #(.ENV_W(ENV_W)) u_env (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (sample_tick),
        .gate         (gate),
        .attack_step  (attack_step),
        .release_step (release_step),
        .level        (level),
        .env          (env),
        .busy         (busy)
    );

    // A zero period behaves as one: reload value never underflows.
    assign reload_c = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign env_s    = $signed({1'b0, env});
    assign prod_c   = PROD_W'(hold) * PROD_W'(env_s);

    // The upstream source updates on the cycle noise_en is high, so its new
    // value is captured one cycle later via cap_pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            noise_en   <= 1'b0;
            cap_pend   <= 1'b0;
            hold       <= '0;
            prod       <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            wave_out   <= '0;
            wave_valid <= 1'b0;
        end else begin
            noise_en <= 1'b0;
            if (sample_tick) begin
                if (cnt == '0) begin
                    cnt      <= reload_c;
                    noise_en <= 1'b1;
                end else begin
                    cnt <= cnt - PERIOD_W'(1);
                end
            end
            cap_pend <= noise_en;
            if (cap_pend) hold <= noise_in;

            if (sample_tick) prod <= prod_c;
            if (v1) wave_out <= NOISE_W'(prod >>> ENV_W);
            v1         <= sample_tick;
            v2         <= v1;
            wave_valid <= v2;
        end
    end

endmodule

// File: tb/tb_noise_voice.sv
// Scoreboard bench for noise_voice with an emulated upstream noise source.
module tb_noise_voice;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        gate;
    logic [15:0] period;
    logic [15:0] attack_step;
    logic [15:0] release_step;
    logic [15:0] level;
    logic        noise_en;
    logic [23:0] noise_in;
    logic [23:0] wave_out;
    logic        wave_valid;
    logic        busy;

    noise_voice dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .period       (period),
        .attack_step  (attack_step),
        .release_step (release_step),
        .level        (level),
        .noise_en     (noise_en),
        .noise_in     (noise_in),
        .wave_out     (wave_out),
        .wave_valid   (wave_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] val;
    } wexp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_seen = 0;
    int          en_q[$];
    wexp_t       wave_q[$];
    logic [23:0] last_wave = '0;

    // Upstream noise source: steps to the next table entry whenever noise_en is seen.
    logic [23:0] ntab [256];
    int unsigned gen_cnt = 0;
    logic        fixed_en = 1'b0;
    logic [23:0] fixed_val = '0;

    always_comb noise_in = fixed_en ? fixed_val : ntab[gen_cnt[7:0]];
    always @(posedge clk) if (noise_en) gen_cnt <= gen_cnt + 1;

    function automatic logic [23:0] gen_value(int unsigned idx);
        return fixed_en ? fixed_val : ntab[idx[7:0]];
    endfunction

    // Reference model: tick-driven counter/envelope, generator advances, event scheduling.
    int                 cnt_m = 0;
    bit                 en_m = 0;
    bit                 hpend_m = 0;
    int unsigned        adv_m = 0;
    logic signed [23:0] hold_m = '0;
    int                 st_m = 0;
    int                 env_m = 0;

    always @(posedge clk) begin
        longint p;
        wexp_t  w;
        cyc++;
        if (!rst_n) begin
            cnt_m = 0; en_m = 0; hpend_m = 0; hold_m = '0; st_m = 0; env_m = 0;
        end else begin
            if (sample_tick) begin
                p     = longint'(hold_m) * longint'(env_m);
                w.cyc = cyc + 2;
                w.val = 24'(p >>> 16);
                wave_q.push_back(w);
            end
            if (hpend_m) hold_m = gen_value(adv_m);
            hpend_m = en_m;
            if (en_m) adv_m++;
            en_m = 0;
            if (sample_tick) begin
                if (cnt_m == 0) begin
                    cnt_m = (period == 0) ? 0 : int'(period) - 1;
                    en_m  = 1;
                    en_q.push_back(cyc);
                end else begin
                    cnt_m--;
                end
                case (st_m)
                    0: begin env_m = 0; if (gate) st_m = 1; end
                    1: if (!gate) st_m = 3;
                       else begin
                           env_m = (env_m + int'(attack_step) < int'(level)) ? env_m + int'(attack_step) : int'(level);
                           if (env_m == int'(level)) st_m = 2;
                       end
                    2: if (!gate) st_m = 3; else env_m = int'(level);
                    default: if (gate) st_m = 1;
                       else begin
                           env_m = (env_m - int'(release_step) > 0) ? env_m - int'(release_step) : 0;
                           if (env_m == 0) st_m = 0;
                       end
                endcase
            end
        end
    end

    // Monitor: pops expected strobes/samples as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            while (en_q.size() > 0 && en_q[0] < cyc) begin
                n_vec++; n_err++;
                $display("FAIL noise_en_missing: got no strobe, expected one at cycle %0d", en_q[0]);
                void'(en_q.pop_front());
            end
            if (noise_en) begin
                en_seen++;
                n_vec++;
                if (en_q.size() == 0 || en_q[0] != cyc) begin
                    n_err++;
                    $display("FAIL noise_en_timing: got strobe at cycle %0d, expected next at %0d",
                             cyc, (en_q.size() > 0) ? en_q[0] : -1);
                end else begin
                    void'(en_q.pop_front());
                end
            end
            while (wave_q.size() > 0 && wave_q[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL wave_valid_missing: got no strobe, expected one at cycle %0d", wave_q[0].cyc);
                void'(wave_q.pop_front());
            end
            if (wave_valid) begin
                n_vec++;
                if (wave_q.size() == 0 || wave_q[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL wave_valid_timing: got strobe at cycle %0d, expected next at %0d",
                             cyc, (wave_q.size() > 0) ? wave_q[0].cyc : -1);
                end else begin
                    if (last_wave !== wave_q[0].val) begin
                        n_err++;
                        $display("FAIL wave_out: got %06h, expected %06h (cycle %0d)", last_wave, wave_q[0].val, cyc);
                    end
                    void'(wave_q.pop_front());
                end
            end
            n_vec++;
            if (busy !== (st_m != 0)) begin
                n_err++;
                $display("FAIL busy: got %0b, expected %0b (cycle %0d)", busy, (st_m != 0), cyc);
            end
        end
        last_wave = wave_out;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic do_tick(int gap);
        sample_tick = 1'b1;
        next();
        sample_tick = 1'b0;
        repeat (gap) next();
    endtask

    task automatic tick_chk(string name, logic [23:0] exp);
        sample_tick = 1'b1;
        next();
        sample_tick = 1'b0;
        next();
        chk(name, 32'(wave_out), 32'(exp));
        repeat (3) next();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wave_q.delete();
        en_q.delete();
        #1;
        chk("rst_noise_en", 32'(noise_en), 32'd0);
        chk("rst_wave_out", 32'(wave_out), 32'd0);
        chk("rst_wave_valid", 32'(wave_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) next();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; sample_tick = 1'b0; gate = 1'b0; period = '0;
        attack_step = '0; release_step = '0; level = '0;
        for (int i = 0; i < 256; i++) ntab[i] = 24'($urandom);
        repeat (3) next();
        do_reset();

        // Divider with period 3, ticks ten cycles apart.
        period = 16'd3;
        base = en_seen;
        repeat (8) do_tick(9);
        chk("div_p3_count", 32'(en_seen - base), 32'd3);

        // Envelope attack, sustain tracking and release observed through a fixed sample.
        do_reset();
        period = 16'd1; fixed_en = 1'b1; fixed_val = 24'h100000;
        tick_chk("env_load", 24'h0);
        gate = 1'b1; attack_step = 16'h4000; level = 16'hC000;
        tick_chk("env_idle_to_attack", 24'h0);
        tick_chk("env_att0", 24'h0);
        tick_chk("env_att1", 24'h040000);
        tick_chk("env_att2", 24'h080000);
        tick_chk("env_sus", 24'h0C0000);
        chk("busy_sustain", 32'(busy), 32'd1);
        level = 16'h8000;
        tick_chk("env_sus_track0", 24'h0C0000);
        tick_chk("env_sus_track1", 24'h080000);
        level = 16'hC000;
        tick_chk("env_sus_track2", 24'h080000);
        gate = 1'b0; release_step = 16'h5000;
        tick_chk("env_to_release", 24'h0C0000);
        tick_chk("env_rel0", 24'h0C0000);
        tick_chk("env_rel1", 24'h070000);
        tick_chk("env_rel2", 24'h020000);
        chk("busy_idle", 32'(busy), 32'd0);

        // Most negative sample at full gain, then full-scale sample at zero gain.
        fixed_val = 24'h800000; attack_step = 16'hFFFF; level = 16'hFFFF; gate = 1'b1;
        tick_chk("mul_setup0", 24'h0);
        tick_chk("mul_setup1", 24'h0);
        tick_chk("mul_neg_full", 24'h800080);
        gate = 1'b0; release_step = 16'hFFFF;
        tick_chk("mul_rel0", 24'h800080);
        tick_chk("mul_rel1", 24'h800080);
        fixed_val = 24'h7FFFFF;
        tick_chk("mul_zero_env0", 24'h0);
        tick_chk("mul_zero_env1", 24'h0);

        // Reset during attack with a noise_en strobe in flight, then period 0.
        fixed_en = 1'b0;
        do_reset();
        period = 16'd2; gate = 1'b1; attack_step = 16'h1000; level = 16'hF000;
        do_tick(3);
        do_tick(3);
        sample_tick = 1'b1;
        next();
        sample_tick = 1'b0;
        chk("pre_rst_noise_en", 32'(noise_en), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        period = 16'd0;
        base = en_seen;
        repeat (6) do_tick(1);
        repeat (2) next();
        chk("period0_count", 32'(en_seen - base), 32'd6);

        // Randomized traffic including back-to-back ticks and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) period = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) gate = ~gate;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       attack_step = 16'h0;
                    1:       attack_step = 16'($urandom_range(1, 16'h0800));
                    default: attack_step = 16'($urandom);
                endcase
                release_step = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
                level        = 16'($urandom);
            end
            fixed_en  = ($urandom_range(0, 9) == 0);
            fixed_val = ($urandom_range(0, 1) == 0) ? 24'h800000 : 24'($urandom);
            do_tick($urandom_range(0, 4));
        end

        repeat (10) next();
        chk("drain_noise_en_q", 32'(en_q.size()), 32'd0);
        chk("drain_wave_q", 32'(wave_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
